// File: rtl/uart_tx_feeder_pkg.sv
// uart_tx_feeder_pkg: state encodings and ASCII constants shared by the UART TX feeder.
package uart_tx_feeder_pkg;
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PULSE  = 3'd1,
      S_ARM    = 3'd2,
      S_WAITLO = 3'd3,
      S_GAP    = 3'd4
   } state_t;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam int unsigned GAP_MAX = 65535;
endpackage

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: producer write port, uart TX handshake and status of the feeder.
interface uart_tx_feeder_if #(parameter int AW = 4);
   logic          flush;
   logic [7:0]    wrData;
   logic          wrValid;
   logic          wrReady;
   logic [7:0]    txData;
   logic          txValid;
   logic          txBusy;
   logic [AW:0]   level;
   logic          idle;
   modport master (output flush, wrData, wrValid, txBusy,
                   input  wrReady, txData, txValid, level, idle);
   modport slave  (input  flush, wrData, wrValid, txBusy,
                   output wrReady, txData, txValid, level, idle);
endinterface

// File: rtl/uart_tx_feeder_sync_fifo.sv
// sync_fifo: registered-pointer FIFO with occupancy count, synchronous reset and flush.
module sync_fifo #(
   parameter int AW    = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_level
);
   localparam int DEPTH = 1 << AW;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_push;
   logic             w_pop;
   // level never exceeds DEPTH, so its top bit alone means full
   assign o_full  = r_level[AW];
   assign o_empty = r_level == '0;
   assign o_level = r_level;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = resetn & i_push & ~o_full & ~i_flush;
   assign w_pop   = resetn & i_pop & ~o_empty & ~i_flush;
   always_ff @(posedge clk) begin
      if (!resetn || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + AW'(w_push);
         r_rd_ptr <= r_rd_ptr + AW'(w_pop);
         r_level  <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers producer bytes and hands them one at a time to the uart TX port.
module uart_tx_feeder
   import uart_tx_feeder_pkg::*;
#(
   parameter int          AW          = 4,
   parameter int unsigned GAP_CYCLES  = 0,
   parameter bit          CRLF_EXPAND = 1'b1
) (
   input  logic             clk,
   input  logic             resetn,
   uart_tx_feeder_if.slave  bus
);
   localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES);
   if (GAP_CYCLES > GAP_MAX) begin : g_gap_check
      $error("GAP_CYCLES must fit in 16 bits");
   end
   state_t      r_state, w_state;
   logic [7:0]  r_tx_data, w_tx_data;
   logic        r_tx_valid, w_tx_valid;
   logic        r_lf_pending, w_lf_pending;
   logic [15:0] r_gap, w_gap;
   logic        w_pop;
   logic        w_full;
   logic        w_empty;
   logic        w_expand;
   logic [7:0]  w_head;
   logic [AW:0] w_level;
   sync_fifo #(.AW(AW), .WIDTH(8)) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_flush (bus.flush),
      .i_push  (bus.wrValid),
      .i_pop   (w_pop),
      .i_data  (bus.wrData),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );
   assign w_expand    = CRLF_EXPAND && w_head == ASCII_LF;
   assign bus.wrReady = ~w_full;
   assign bus.level   = w_level;
   assign bus.txData  = r_tx_data;
   assign bus.txValid = r_tx_valid;
   assign bus.idle    = w_empty & ~r_lf_pending & (r_state == S_IDLE);
   always_comb begin
      w_state      = r_state;
      w_tx_data    = r_tx_data;
      w_tx_valid   = 1'b0;
      w_lf_pending = r_lf_pending;
      w_gap        = r_gap;
      w_pop        = 1'b0;
      case (r_state)
         S_IDLE: begin
            // busy is sampled here so a pulse is never launched into a busy uart
            if (!bus.flush && !bus.txBusy && (r_lf_pending || !w_empty)) begin
               w_pop        = ~r_lf_pending;
               w_tx_data    = r_lf_pending ? ASCII_LF : (w_expand ? ASCII_CR : w_head);
               w_lf_pending = ~r_lf_pending & w_expand;
               w_tx_valid   = 1'b1;
               w_state      = S_PULSE;
            end
         end
         S_PULSE:  w_state = S_ARM;
         S_ARM:    w_state = S_WAITLO;
         S_WAITLO: begin
            if (!bus.txBusy) begin
               w_gap   = GAP_LOAD;
               w_state = (GAP_CYCLES != 0) ? S_GAP : S_IDLE;
            end
         end
         S_GAP: begin
            w_gap   = (r_gap == 16'd0) ? 16'd0 : r_gap - 16'd1;
            w_state = (r_gap <= 16'd1) ? S_IDLE : S_GAP;
         end
         default: w_state = S_IDLE;
      endcase
      // a transfer already handed to the uart runs to completion through its gap
      if (bus.flush) begin
         w_lf_pending = 1'b0;
         w_state      = (r_state == S_WAITLO || r_state == S_GAP) ? w_state : S_IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state      <= S_IDLE;
         r_tx_data    <= 8'h00;
         r_tx_valid   <= 1'b0;
         r_lf_pending <= 1'b0;
         r_gap        <= 16'd0;
      end else begin
         r_state      <= w_state;
         r_tx_data    <= w_tx_data;
         r_tx_valid   <= w_tx_valid;
         r_lf_pending <= w_lf_pending;
         r_gap        <= w_gap;
      end
   end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed checks of the feeder against a simple uart busy model.
module tb_uart_tx_feeder;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   uart_tx_feeder_if #(.AW(4)) if0 ();
   uart_tx_feeder_if #(.AW(4)) if1 ();

   uart_tx_feeder #(.AW(4), .GAP_CYCLES(0), .CRLF_EXPAND(1'b1)) u_dut0 (
      .clk(clk), .resetn(resetn), .bus(if0));
   uart_tx_feeder #(.AW(4), .GAP_CYCLES(50), .CRLF_EXPAND(1'b0)) u_dut1 (
      .clk(clk), .resetn(resetn), .bus(if1));

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   logic stall0 = 1'b0;
   int bcnt0 = 0, bcnt1 = 0;
   int viol0 = 0, viol1 = 0;
   int fall0 = -1, fall1 = -1;
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   int gaps1[$];

   // uart stand-in: busy rises the cycle after a pulse and stays up for 20 cycles
   assign if0.txBusy = stall0 || bcnt0 != 0;
   assign if1.txBusy = bcnt1 != 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      if (!resetn) bcnt0 <= 0;
      else if (if0.txValid) begin
         q0.push_back(if0.txData);
         if (if0.txBusy) viol0 <= viol0 + 1;
         bcnt0 <= 20;
      end else if (bcnt0 != 0) begin
         bcnt0 <= bcnt0 - 1;
         if (bcnt0 == 1) fall0 <= cyc;
      end
   end
   always @(posedge clk) begin
      if (!resetn) bcnt1 <= 0;
      else if (if1.txValid) begin
         q1.push_back(if1.txData);
         if (if1.txBusy) viol1 <= viol1 + 1;
         if (fall1 >= 0) gaps1.push_back(cyc - fall1);
         bcnt1 <= 20;
      end else if (bcnt1 != 0) begin
         bcnt1 <= bcnt1 - 1;
         if (bcnt1 == 1) fall1 <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push0(input logic [7:0] d);
      if0.wrData = d;
      if0.wrValid = 1'b1;
      @(negedge clk);
      if0.wrValid = 1'b0;
   endtask

   task automatic push1(input logic [7:0] d);
      if1.wrData = d;
      if1.wrValid = 1'b1;
      @(negedge clk);
      if1.wrValid = 1'b0;
   endtask

   task automatic wait_idle(input int which, input int max, input string tag);
      int n = 0;
      while (!(which == 0 ? (if0.idle && !if0.txBusy) : (if1.idle && !if1.txBusy)) && n < max) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(n < max), 32'd1);
   endtask

   task automatic wait_busy0(input string tag);
      int n = 0;
      while (!if0.txBusy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(n < 50), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      if0.flush = 1'b0; if0.wrValid = 1'b0; if0.wrData = 8'h00;
      if1.flush = 1'b0; if1.wrValid = 1'b0; if1.wrData = 8'h00;
      // reset held for two edges
      repeat (2) @(negedge clk);
      chk("rst_txvalid", 32'(if0.txValid), 32'd0);
      chk("rst_level",   32'(if0.level),   32'd0);
      chk("rst_wrready", 32'(if0.wrReady), 32'd1);
      chk("rst_idle",    32'(if0.idle),    32'd1);
      chk("rst_txdata",  32'(if0.txData),  32'h00);
      chk("rst_idle1",   32'(if1.idle),    32'd1);
      resetn = 1'b1;
      @(negedge clk);

      // "hi" back to back, first pulse two edges after the write
      b = q0.size();
      if0.wrData = 8'h68; if0.wrValid = 1'b1;
      @(negedge clk);
      chk("hi_lat_early", 32'(if0.txValid), 32'd0);
      if0.wrData = 8'h69;
      @(negedge clk);
      if0.wrValid = 1'b0;
      chk("hi_lat_valid", 32'(if0.txValid), 32'd1);
      chk("hi_lat_data",  32'(if0.txData),  32'h68);
      chk("hi_level",     32'(if0.level),   32'd1);
      @(negedge clk);
      chk("hi_pulse_one", 32'(if0.txValid), 32'd0);
      wait_idle(0, 200, "hi_done");
      chk("hi_count", 32'(q0.size() - b), 32'd2);
      chk("hi_b0",    32'(q0[b]),         32'h68);
      chk("hi_b1",    32'(q0[b+1]),       32'h69);
      chk("hi_idle",  32'(if0.idle),      32'd1);

      // LF expansion on, then off
      b = q0.size();
      push0(8'h0A);
      wait_idle(0, 200, "lf0_done");
      chk("lf0_count", 32'(q0.size() - b), 32'd2);
      chk("lf0_cr",    32'(q0[b]),         32'h0D);
      chk("lf0_lf",    32'(q0[b+1]),       32'h0A);
      b = q1.size();
      push1(8'h0A);
      wait_idle(1, 300, "lf1_done");
      chk("lf1_count", 32'(q1.size() - b), 32'd1);
      chk("lf1_lf",    32'(q1[b]),         32'h0A);

      // inter-byte gap of 50 cycles
      b = q1.size();
      push1(8'h31);
      push1(8'h32);
      wait_idle(1, 400, "gap_done");
      chk("gap_count", 32'(q1.size() - b), 32'd2);
      chk("gap_b0",    32'(q1[b]),         32'h31);
      chk("gap_b1",    32'(q1[b+1]),       32'h32);
      chk("gap_min",   32'(gaps1[gaps1.size()-1] >= 50), 32'd1);

      // fill to 16 with the uart stalled; the 17th write is dropped
      b = q0.size();
      stall0 = 1'b1;
      for (int i = 0; i < 16; i++) push0(8'h40 + 8'(i));
      chk("full_level",   32'(if0.level),   32'd16);
      chk("full_wrready", 32'(if0.wrReady), 32'd0);
      push0(8'h99);
      chk("full_level17", 32'(if0.level),   32'd16);
      chk("full_novalid", 32'(if0.txValid), 32'd0);
      stall0 = 1'b0;
      wait_idle(0, 1000, "full_done");
      chk("full_count", 32'(q0.size() - b), 32'd16);
      for (int i = 0; i < 16; i++) chk("full_byte", 32'(q0[b+i]), 32'h40 + 32'(i));

      // flush with bytes queued while byte 1 is on the line
      b = q0.size();
      for (int i = 0; i < 5; i++) push0(8'h50 + 8'(i));
      wait_busy0("flush_busy");
      chk("flush_pre_level", 32'(if0.level), 32'd4);
      if0.flush = 1'b1;
      @(negedge clk);
      if0.flush = 1'b0;
      chk("flush_level", 32'(if0.level), 32'd0);
      wait_idle(0, 200, "flush_done");
      chk("flush_count", 32'(q0.size() - b), 32'd1);
      chk("flush_b0",    32'(q0[b]),         32'h50);

      // reset in the middle of waiting for busy to drop
      push0(8'h60);
      wait_busy0("rstmid_busy");
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      chk("rstmid_txvalid", 32'(if0.txValid), 32'd0);
      chk("rstmid_idle",    32'(if0.idle),    32'd1);
      chk("rstmid_level",   32'(if0.level),   32'd0);
      chk("rstmid_txdata",  32'(if0.txData),  32'h00);
      resetn = 1'b1;
      @(negedge clk);
      b = q0.size();
      push0(8'h7E);
      wait_idle(0, 200, "after_rst_done");
      chk("after_rst_count", 32'(q0.size() - b), 32'd1);
      chk("after_rst_b0",    32'(q0[b]),         32'h7E);
      chk("overlap0", 32'(viol0), 32'd0);
      chk("overlap1", 32'(viol1), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
